// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
// Includes FSM state encodings, opcode map and ALU operation codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_AND  = 2;
    localparam int unsigned OP_OR   = 3;
    localparam int unsigned OP_ORI  = 4;
    localparam int unsigned OP_XOR  = 5;
    localparam int unsigned OP_SLT  = 6;
    localparam int unsigned OP_SW   = 7;
    localparam int unsigned OP_LW   = 8;
    localparam int unsigned OP_BLT  = 9;
    // 4-bit encoding of halt; wider opcode fields use all ones.
    localparam int unsigned OP_HALT = 15;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_OR  = 3;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational classification of an opcode into its instruction class.
// Shared by the control FSM's next-state logic and its output decode.
module opcode_class_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] op,
    output logic                is_rtype,
    output logic                is_ori,
    output logic                is_lw,
    output logic                is_sw,
    output logic                is_blt,
    output logic                is_halt,
    output logic                is_illegal
);

    always_comb begin
        is_rtype   = (op == OPCODE_W'(OP_ADD)) || (op == OPCODE_W'(OP_SUB)) ||
                     (op == OPCODE_W'(OP_AND)) || (op == OPCODE_W'(OP_OR))  ||
                     (op == OPCODE_W'(OP_XOR)) || (op == OPCODE_W'(OP_SLT));
        is_ori     = (op == OPCODE_W'(OP_ORI));
        is_sw      = (op == OPCODE_W'(OP_SW));
        is_lw      = (op == OPCODE_W'(OP_LW));
        is_blt     = (op == OPCODE_W'(OP_BLT));
        is_halt    = &op;
        is_illegal = !(is_rtype || is_ori || is_sw || is_lw || is_blt || is_halt);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit datapath.
// Handshakes with variable-latency memory and counts retired instructions.
module multicycle_control_unit
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALUCTR_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                reg_dst,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                ext_op,
    output logic [ALUCTR_W-1:0] alu_ctr,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    state_t              state;
    state_t              state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] dec_op;
    logic                retire;
    logic                is_rtype, is_ori, is_lw, is_sw, is_blt, is_halt, is_illegal;

    // DECODE classifies the live opcode; later states use the latched copy.
    assign dec_op = (state == ST_DECODE) ? opcode : op_q;

    opcode_class_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_class (
        .op        (dec_op),
        .is_rtype  (is_rtype),
        .is_ori    (is_ori),
        .is_lw     (is_lw),
        .is_sw     (is_sw),
        .is_blt    (is_blt),
        .is_halt   (is_halt),
        .is_illegal(is_illegal)
    );

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            ST_FETCH:  if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_illegal)   state_next = ST_FETCH;
                else if (is_halt) state_next = ST_HALT;
                else              state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_blt) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (is_sw) begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FETCH;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) op_q <= opcode;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        ext_op     = 1'b0;
        alu_ctr    = '0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                // A completing fetch must not load IR/PC while reset is held.
                ir_write = mem_ready && !rst;
                pc_write = mem_ready && !rst;
            end
            ST_DECODE: illegal = is_illegal;
            ST_EXEC: begin
                alu_src = is_ori || is_lw || is_sw;
                ext_op  = is_lw || is_sw || is_blt;
                branch  = is_blt;
                if (is_rtype)    alu_ctr = ALUCTR_W'(op_q[2:0]);
                else if (is_ori) alu_ctr = ALUCTR_W'(ALU_OR);
                else if (is_blt) alu_ctr = ALUCTR_W'(ALU_SUB);
                else             alu_ctr = ALUCTR_W'(ALU_ADD);
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_lw;
                reg_dst    = is_rtype;
            end
            ST_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: per-instruction expected output traces from an opcode-class model,
// plus a narrow-counter instance checked for modulo-4 wrap.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        ir_write;
        logic        pc_write;
        logic        branch;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        ext_op;
        logic [2:0]  alu_ctr;
        logic        halted;
        logic        illegal;
        logic [15:0] count;
    } vec_t;

    localparam int C_R = 0, C_ORI = 1, C_SW = 2, C_LW = 3, C_BLT = 4, C_HALT = 5, C_ILL = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, ir_write, pc_write, branch, reg_dst, alu_src;
    logic        mem_to_reg, reg_write, ext_op, halted, illegal;
    logic [2:0]  alu_ctr;
    logic [15:0] instr_count;

    logic [3:0]  d2_opcode = 4'd0;
    logic        d2_mem_ready = 1'b1;
    logic        d2_mem_req, d2_mem_we, d2_ir_write, d2_pc_write, d2_branch, d2_reg_dst;
    logic        d2_alu_src, d2_mem_to_reg, d2_reg_write, d2_ext_op, d2_halted, d2_illegal;
    logic [2:0]  d2_alu_ctr;
    logic [1:0]  d2_count;

    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;
    int   k2 = 0;
    vec_t exp_q[$];

    multicycle_control_unit #(.OPCODE_W(4), .ALUCTR_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .ext_op(ext_op), .alu_ctr(alu_ctr), .halted(halted),
        .illegal(illegal), .instr_count(instr_count)
    );

    multicycle_control_unit #(.OPCODE_W(4), .ALUCTR_W(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .opcode(d2_opcode), .mem_ready(d2_mem_ready),
        .mem_req(d2_mem_req), .mem_we(d2_mem_we), .ir_write(d2_ir_write), .pc_write(d2_pc_write),
        .branch(d2_branch), .reg_dst(d2_reg_dst), .alu_src(d2_alu_src), .mem_to_reg(d2_mem_to_reg),
        .reg_write(d2_reg_write), .ext_op(d2_ext_op), .alu_ctr(d2_alu_ctr), .halted(d2_halted),
        .illegal(d2_illegal), .instr_count(d2_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t sample();
        vec_t v;
        v.mem_req    = mem_req;
        v.mem_we     = mem_we;
        v.ir_write   = ir_write;
        v.pc_write   = pc_write;
        v.branch     = branch;
        v.reg_dst    = reg_dst;
        v.alu_src    = alu_src;
        v.mem_to_reg = mem_to_reg;
        v.reg_write  = reg_write;
        v.ext_op     = ext_op;
        v.alu_ctr    = alu_ctr;
        v.halted     = halted;
        v.illegal    = illegal;
        v.count      = instr_count;
        return v;
    endfunction

    task automatic check_vec(input string name, input vec_t got, input vec_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // Monitor: one scoreboard entry per clock of the main DUT, plus the wrap counter.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                k2 = 0;
                e = '0;
                e.mem_req = 1'b1;
                check_vec("reset_outputs", sample(), e);
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_vec("cycle", sample(), e);
                end
                checks++;
                if (d2_count !== 2'((k2 / 4) % 4)) begin
                    errors++;
                    $display("FAIL cnt2_wrap got=%0d want=%0d", d2_count, (k2 / 4) % 4);
                end
                k2++;
            end
        end
    end

    function automatic int op_class(input int op);
        case (op)
            0, 1, 2, 3, 5, 6: return C_R;
            4:       return C_ORI;
            7:       return C_SW;
            8:       return C_LW;
            9:       return C_BLT;
            15:      return C_HALT;
            default: return C_ILL;
        endcase
    endfunction

    function automatic vec_t base();
        vec_t v = '0;
        v.count = 16'(model_count);
        return v;
    endfunction

    function automatic logic [3:0] noise_op();
        return 4'($urandom);
    endfunction

    function automatic logic noise_rdy();
        return 1'($urandom);
    endfunction

    task automatic step(input vec_t e, input logic rdy, input logic [3:0] op);
        opcode    = op;
        mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int op, input int fw, input int mw);
        vec_t v;
        int   c;
        c = op_class(op);
        for (int i = 0; i < fw; i++) begin
            v = base(); v.mem_req = 1'b1;
            step(v, 1'b0, noise_op());
        end
        v = base(); v.mem_req = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step(v, 1'b1, noise_op());
        v = base(); v.illegal = (c == C_ILL);
        step(v, noise_rdy(), 4'(op));
        if (c == C_ILL) return;
        if (c == C_HALT) begin
            for (int i = 0; i < 8; i++) begin
                v = base(); v.halted = 1'b1;
                step(v, noise_rdy(), noise_op());
            end
            return;
        end
        v = base();
        case (c)
            C_R:   v.alu_ctr = 3'(op);
            C_ORI: begin v.alu_ctr = 3'd3; v.alu_src = 1'b1; end
            C_BLT: begin v.alu_ctr = 3'd1; v.ext_op = 1'b1; v.branch = 1'b1; end
            default: begin v.ext_op = 1'b1; v.alu_src = 1'b1; end
        endcase
        step(v, noise_rdy(), noise_op());
        if (c == C_BLT) begin model_count++; return; end
        if (c == C_SW || c == C_LW) begin
            for (int i = 0; i <= mw; i++) begin
                v = base(); v.mem_req = 1'b1; v.mem_we = (c == C_SW);
                step(v, (i == mw), noise_op());
            end
            if (c == C_SW) begin model_count++; return; end
        end
        v = base(); v.reg_write = 1'b1; v.mem_to_reg = (c == C_LW); v.reg_dst = (c == C_R);
        step(v, noise_rdy(), noise_op());
        model_count++;
    endtask

    initial begin
        vec_t v;
        int   rtype_ops[6] = '{0, 1, 2, 3, 5, 6};
        int   op;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        foreach (rtype_ops[i]) run_instr(rtype_ops[i], 0, 0);
        run_instr(8, 0, 2);
        run_instr(7, 0, 2);
        run_instr(9, 0, 0);
        run_instr(10, 0, 0);
        run_instr(4, 1, 0);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 14);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset while a store is stalled in MEM.
        v = base(); v.mem_req = 1'b1; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step(v, 1'b1, 4'd0);
        v = base();
        step(v, 1'b1, 4'd7);
        v = base(); v.ext_op = 1'b1; v.alu_src = 1'b1;
        step(v, 1'b0, 4'd0);
        v = base(); v.mem_req = 1'b1; v.mem_we = 1'b1;
        step(v, 1'b0, 4'd0);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        v = '0; v.mem_req = 1'b1;
        check_vec("async_reset_in_mem", sample(), v);
        model_count = 0;
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(5, 0, 0);
        run_instr(8, 1, 1);
        run_instr(12, 0, 0);
        run_instr(15, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
